// File: rtl/r_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r_arb_pkg
// Description : Shared types, width helpers and round-robin search for the
//               R-channel burst arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package r_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int c_max_src = 64;
    localparam int c_idx_w   = $clog2(c_max_src);

    typedef struct packed {
        logic               found;
        logic [c_idx_w-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned src_idx_w(input int unsigned num_src);
        if (num_src > 1) return $clog2(num_src);
        return 1;
    endfunction

    function automatic int unsigned beat_cnt_w(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

    // First set bit at or above ptr, wrapping at num_src.
    function automatic rr_pick_t rr_pick(input logic [c_max_src-1:0] req,
                                         input int unsigned          ptr,
                                         input int unsigned          num_src);
        rr_pick_t    pick;
        int unsigned s;
        pick = '0;
        for (int unsigned k = 0; k < c_max_src; k++) begin
            s = ptr + k;
            if (s >= num_src) s = s - num_src;
            if ((k < num_src) && !pick.found && req[s[c_idx_w-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = s[c_idx_w-1:0];
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/r_if.sv
`default_nettype none
// ============================================================================
// Module      : r_if
// Description : AXI-style R-channel stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface r_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;

    modport sender   (output valid, id, data, resp, last, input  ready);
    modport receiver (input  valid, id, data, resp, last, output ready);
endinterface
`default_nettype wire

// File: rtl/rr_pick_comb.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_comb
// Description : Combinational round-robin picker; one-hot and encoded grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_comb
    import r_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_grant_oh,
    output logic [SRC_W-1:0]   o_grant_idx
);
    logic [c_max_src-1:0] w_req_ext;
    rr_pick_t             w_pick;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[NUM_SRC-1:0] = i_req;
        w_pick                 = rr_pick(w_req_ext, 32'(i_ptr), NUM_SRC);
    end

    assign o_grant_idx = w_pick.idx[SRC_W-1:0];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_oh
        assign o_grant_oh[k] = w_pick.found && (w_pick.idx == c_idx_w'(k));
    end
endmodule
`default_nettype wire

// File: rtl/r_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : r_burst_arbiter
// Description : Burst-locked round-robin merge of NUM_SRC R-channel streams.
// Revision    : 1.0 - initial release
// ============================================================================
module r_burst_arbiter
    import r_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              in_valid,
    output logic [NUM_SRC-1:0]              in_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]     in_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_SRC*2-1:0]            in_resp,
    input  logic [NUM_SRC-1:0]              in_last,
    r_if.sender                             out_r,
    output logic [src_idx_w(NUM_SRC)-1:0]   out_src,
    output logic                            busy,
    output logic                            overrun_err
);
    localparam int c_src_w = src_idx_w(NUM_SRC);
    localparam int c_cnt_w = beat_cnt_w(MAX_BEATS);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [c_src_w-1:0]   grant_q;
    logic [c_src_w-1:0]   rr_ptr_q;
    logic [c_cnt_w-1:0]   beat_cnt_q;
    logic [NUM_SRC-1:0]   w_pick_oh;
    logic [c_src_w-1:0]   w_pick_idx;
    logic                 w_found;
    logic                 w_xfer;

    logic [ID_WIDTH-1:0]   w_id   [NUM_SRC];
    logic [DATA_WIDTH-1:0] w_data [NUM_SRC];
    logic [1:0]            w_resp [NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign w_id[k]   = in_id[k*ID_WIDTH +: ID_WIDTH];
        assign w_data[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_resp[k] = in_resp[k*2 +: 2];
    end

    rr_pick_comb #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (c_src_w)
    ) u_pick (
        .i_req       (in_valid),
        .i_ptr       (rr_ptr_q),
        .o_grant_oh  (w_pick_oh),
        .o_grant_idx (w_pick_idx)
    );

    assign w_found = |w_pick_oh;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        in_ready    = '0;
        out_r.valid = 1'b0;
        out_r.id    = '0;
        out_r.data  = '0;
        out_r.resp  = '0;
        out_r.last  = 1'b0;
        out_src     = '0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) w_state_nxt = LOCKED;
            end
            LOCKED: begin
                busy              = 1'b1;
                out_src           = grant_q;
                out_r.valid       = in_valid[grant_q];
                out_r.id          = w_id[grant_q];
                out_r.data        = w_data[grant_q];
                out_r.resp        = w_resp[grant_q];
                out_r.last        = in_last[grant_q];
                in_ready[grant_q] = out_r.ready;
                w_xfer            = in_valid[grant_q] & out_r.ready;
                if (w_xfer && in_last[grant_q]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter saturates so an overrunning burst cannot wrap back to a legal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            overrun_err <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_found) begin
                grant_q    <= w_pick_idx;
                beat_cnt_q <= '0;
            end
        end else if (w_xfer) begin
            if (beat_cnt_q != c_cnt_w'(MAX_BEATS)) beat_cnt_q <= beat_cnt_q + 1'b1;
            if (in_last[grant_q]) begin
                rr_ptr_q <= (grant_q == c_src_w'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
            end else if (beat_cnt_q == c_cnt_w'(MAX_BEATS - 1)) begin
                overrun_err <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/r_burst_arbiter.md
# r_burst_arbiter

Burst-locked round-robin arbiter that shares one R-channel stream (toward the ID ordering unit) between `NUM_SRC` upstream response buffers, each emitting whole bursts. A grant is held from the first beat until the RLAST beat completes, so bursts never interleave on the output. The block also tracks the beat count of the active burst and flags protocol overruns.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesting sources, ≥2.
- `ID_WIDTH`, 4: RID width.
- `DATA_WIDTH`, 64: RDATA width.
- `MAX_BEATS`, 32: longest legal burst.

Ports:
- `clk`  in  1  the block's single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  NUM_SRC  per-source beat valid.
- `in_ready`  out  NUM_SRC  per-source beat ready.
- `in_id`  in  NUM_SRC*ID_WIDTH  per-source RID. Source k occupies slice `[k*ID_WIDTH +: ID_WIDTH]`.
- `in_data`  in  NUM_SRC*DATA_WIDTH  per-source RDATA, same slicing.
- `in_resp`  in  NUM_SRC*2  per-source RRESP.
- `in_last`  in  NUM_SRC  per-source RLAST.
- `out_r`  r_if.sender  —  merged stream (valid, ready, id, data, resp, last).
- `out_src`  out  $clog2(NUM_SRC)  index of the granted source. Valid while `out_r.valid`.
- `busy`  out  1  high in LOCKED.
- `overrun_err`  out  1  sticky. Set when a burst exceeds MAX_BEATS beats.

## Operation
- FSM states: IDLE, LOCKED. Registers: `grant_q`, `rr_ptr_q`, `beat_cnt_q` (width $clog2(MAX_BEATS+1)), `overrun_err`.
- IDLE:
  - `in_ready` is all 0 and `out_r.valid` is 0.
  - If any `in_valid` is high, pick the first requester at or after `rr_ptr_q`, searching upward with wrap-around.
  - Load `grant_q` with that source, clear `beat_cnt_q`, and go to LOCKED.
- LOCKED, for granted source g:
  - `out_r.{valid,id,data,resp,last}` = source g's fields.
  - `in_ready[g]` = `out_r.ready`; all other `in_ready` bits are 0.
  - On each transfer (`out_r.valid & out_r.ready`), `beat_cnt_q` increments. It saturates at MAX_BEATS.
  - Transfer with `last` = 1: go to IDLE and set `rr_ptr_q` = (g+1) mod NUM_SRC.
  - Transfer with `last` = 0 while `beat_cnt_q` = MAX_BEATS-1: set `overrun_err`. The grant is held until `last` arrives.
- Non-granted sources stall. Their valid and data are ignored and no beats are dropped.
- A granted source that deasserts valid mid-burst keeps the grant. `out_r.valid` follows source g.
- Output fields outside LOCKED are driven to 0.

## Timing
- Reset values: state = IDLE, `grant_q` = 0, `rr_ptr_q` = 0, `beat_cnt_q` = 0, `overrun_err` = 0, `busy` = 0, `out_src` = 0, `out_r` all 0, `in_ready` all 0.
- Arbitration latency: a request first seen in IDLE at cycle t is granted at t+1. Its first beat can transfer at t+1.
- Data path from source g to `out_r` is combinational while LOCKED, so there is zero added beat latency.
- One IDLE bubble cycle separates consecutive bursts, including bursts from the same source.
- Single-beat burst: LOCKED for one cycle, then IDLE.
- Requests that arrive while LOCKED are considered at the next IDLE cycle.
- Reset asserted mid-burst: the FSM returns to IDLE and the partially forwarded burst is abandoned. Upstream is reset by the same `rst`.
- `overrun_err` is cleared only by `rst`.

## Structure
- Package `r_arb_pkg`:
  - state enum `arb_state_e` {IDLE, LOCKED};
  - localparams for source-index and beat-count widths;
  - function `rr_pick(req, ptr)`, which returns the index and a found flag.
- One natural sub-module: `rr_pick_comb`, combinational, inputs NUM_SRC request bits plus ptr, outputs one-hot grant and encoded index. The FSM, counters and mux stay in `r_burst_arbiter`.

## Test plan
- Single source 1 raises a 4-beat burst, `out_r.ready`=1 → grant one cycle later, 4 beats with `out_src`=1 and ids/data unchanged, `last` on beat 4, `rr_ptr_q`=2, one bubble cycle.
- All 4 sources continuously valid with 2-beat bursts → grant order 0,1,2,3,0, no interleaving, each burst contiguous.
- Source 2 mid-burst with `out_r.ready` toggled 1,0,1,0 and source 0 requesting → source 0 never gets `in_ready` until source 2's `last` transfers. Beats are not duplicated or dropped.
- Source 3 sends 33 beats with MAX_BEATS=32 → `overrun_err` rises after beat 32 transfers, stays high, and the arbiter releases only after `last`.
- `rst` asserted at beat 2 of an 8-beat burst → next cycle IDLE, `in_ready` all 0, `out_r.valid`=0, `rr_ptr_q`=0, `overrun_err`=0.
- Sources 0 and 3 request with `rr_ptr_q`=1 → source 3 granted first (wrap-around search), then source 0.
